// File: rtl/wd_fault_if.sv
// Watchdog fault handler bus: watchdog levels, sample stream,
// host clear handshake and status.
interface wd_fault_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic                     wd_warning;
    logic                     wd_triggered;
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid_in;
    logic signed [DATA_W-1:0] sample_out;
    logic                     sample_valid_out;
    logic                     clear_req;
    logic                     clear_ack;
    logic                     wd_force_reset;
    logic                     tx_enable;
    logic                     warn;
    logic                     fault;
    logic [CNT_W-1:0]         fault_count;
    logic [2:0]               state;

    modport master (
        output wd_warning, wd_triggered,
        output sample_in, sample_valid_in, clear_req,
        input  sample_out, sample_valid_out, clear_ack,
        input  wd_force_reset, tx_enable, warn, fault,
        input  fault_count, state
    );

    modport slave (
        input  wd_warning, wd_triggered,
        input  sample_in, sample_valid_in, clear_req,
        output sample_out, sample_valid_out, clear_ack,
        output wd_force_reset, tx_enable, warn, fault,
        output fault_count, state
    );
endinterface

// File: rtl/wd_fault_handler.sv
// Ramps the carrier to zero on a watchdog trip, mutes TX and
// re-arms the watchdog after a successful host clear.
module wd_fault_handler #(
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 16,
    parameter int RAMP_DIV  = 4,
    parameter int HOLDOFF   = 8,
    parameter int CNT_W     = 8
) (
    input  logic      clk,
    input  logic      rst,
    wd_fault_if.slave bus
);
    localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [GAIN_W-1:0] GAIN_FS = '1;
    localparam logic [GAIN_W-1:0] STEP    = GAIN_W'(RAMP_STEP);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_WARN    = 3'd1,
        S_RAMP    = 3'd2,
        S_MUTED   = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [GAIN_W-1:0]          r_gain;
    logic [TW-1:0]              r_tick;
    logic [HW-1:0]              r_hold;
    logic signed [DATA_W-1:0]   r_out;
    logic                       r_valid;
    logic                       r_ack;
    logic                       r_frst;
    logic                       r_tx;
    logic                       r_warn;
    logic                       r_fault;
    logic [CNT_W-1:0]           r_cnt;
    logic                       w_tick_end;
    logic                       w_hold_end;
    logic                       w_enter_ramp;
    logic                       w_recovered;
    logic                       w_cnt_inc;
    logic signed [DATA_W+GAIN_W:0] w_prod;

    assign w_tick_end = (r_tick == TW'(RAMP_DIV - 1));
    assign w_hold_end = (r_hold == HW'(HOLDOFF - 1));
    assign w_prod = bus.sample_in * $signed({1'b0, r_gain});

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RUN, S_WARN: begin
                if (bus.wd_triggered)
                    w_next = S_RAMP;
                else if (bus.wd_warning)
                    w_next = S_WARN;
                else
                    w_next = S_RUN;
            end
            S_RAMP:
                if (r_gain == '0)
                    w_next = S_MUTED;
            S_MUTED:
                if (bus.clear_req && !bus.wd_triggered)
                    w_next = S_RECOVER;
            S_RECOVER:
                if (w_hold_end)
                    w_next = bus.wd_triggered ? S_MUTED : S_RUN;
            default: w_next = S_RUN;
        endcase
    end

    assign w_enter_ramp = (w_next == S_RAMP) && (r_state != S_RAMP);
    assign w_recovered  = (r_state == S_RECOVER) && (w_next == S_RUN);
    // Counts fresh trips and failed recoveries alike
    assign w_cnt_inc = w_enter_ramp ||
                       ((r_state == S_RECOVER) && (w_next == S_MUTED));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_RUN;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gain  <= GAIN_FS;
            r_tick  <= '0;
            r_hold  <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
            r_frst  <= 1'b0;
            r_tx    <= 1'b0;
            r_warn  <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= bus.sample_valid_in;
            r_ack   <= w_recovered;
            r_frst  <= (r_state == S_MUTED) && (w_next == S_RECOVER);
            r_tx    <= w_next inside {S_RUN, S_WARN, S_RAMP};
            r_warn  <= (w_next == S_WARN);

            if (bus.sample_valid_in) begin
                unique case (r_state)
                    S_RUN, S_WARN: r_out <= bus.sample_in;
                    S_RAMP:        r_out <= DATA_W'(w_prod >>> GAIN_W);
                    default:       r_out <= '0;
                endcase
            end

            if (r_state != S_RAMP || w_tick_end)
                r_tick <= '0;
            else
                r_tick <= r_tick + 1'b1;

            if (r_state != S_RECOVER)
                r_hold <= '0;
            else
                r_hold <= r_hold + 1'b1;

            if (r_state == S_RAMP && w_tick_end)
                r_gain <= (r_gain < STEP) ? '0 : r_gain - STEP;
            else if (w_recovered)
                r_gain <= GAIN_FS;

            if (w_enter_ramp)
                r_fault <= 1'b1;
            else if (w_recovered)
                r_fault <= 1'b0;

            if (w_cnt_inc && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.sample_out       = r_out;
    assign bus.sample_valid_out = r_valid;
    assign bus.clear_ack        = r_ack;
    assign bus.wd_force_reset   = r_frst;
    assign bus.tx_enable        = r_tx;
    assign bus.warn             = r_warn;
    assign bus.fault            = r_fault;
    assign bus.fault_count      = r_cnt;
    assign bus.state            = r_state;
endmodule
